// File: rtl/priority_scan_pkg.sv
// Shared types for the priority scan encoder: FSM state, beat register layout
// and the index-width helper.
package priority_scan_pkg;

  localparam int IDX_MAX_W = 16;

  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

  // idx is sized for the widest supported vector; the top uses the low W bits
  typedef struct packed {
    logic [IDX_MAX_W-1:0] idx;
    logic                 last;
    logic                 none;
  } beat_t;

endpackage

// File: rtl/priority_scan_encoder_pick.sv
// Combinational priority pick: index of the highest (or lowest) set bit,
// plus any-set and exactly-one-set flags.
module priority_pick
  import priority_scan_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 0,
  localparam int W        = idx_w(N)
) (
  input  logic [N-1:0] vec,
  output logic [W-1:0] idx,
  output logic         found,
  output logic         single
);

  // Later loop iterations overwrite earlier ones, so the loop direction sets priority
  always_comb begin
    idx = '0;
    if (LSB_FIRST != 0) begin
      for (int i = N - 1; i >= 0; i--)
        if (vec[i]) idx = W'(i);
    end else begin
      for (int i = 0; i < N; i++)
        if (vec[i]) idx = W'(i);
    end
  end

  assign found  = |vec;
  assign single = found && ((vec & (vec - N'(1))) == '0);

endmodule

// File: rtl/priority_scan_encoder.sv
// Sequential priority encoder: one beat per set bit of a captured vector.
// Optional PRIORITY_SCAN_COUNT_EN adds out_count / out_remaining ports.
module priority_scan_encoder
  import priority_scan_pkg::*;
#(
  parameter int N         = 8,
  parameter int LSB_FIRST = 0,
  localparam int W        = idx_w(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] in_vec,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_idx,
  output logic         out_last,
  output logic         out_none,
`ifdef PRIORITY_SCAN_COUNT_EN
  output logic [W:0]   out_count,
  output logic [W:0]   out_remaining,
`endif
  output logic         busy
);

  state_t       state;
  beat_t        beat, nb;
  logic [N-1:0] pending, nxt;
  logic [W-1:0] pick_idx;
  logic         pick_found, pick_single;
  logic         take, fire;

  assign take = (state == IDLE) && in_valid;
  assign fire = (state == SCAN) && out_ready;

  // The picker looks at what pending will be next cycle, so the following
  // beat is ready to register on the same edge that retires the current one.
  always_comb begin
    nxt = pending;
    if (take)      nxt = in_vec;
    else if (fire) nxt = pending & ~(N'(1) << beat.idx[W-1:0]);
  end

  priority_pick #(.N(N), .LSB_FIRST(LSB_FIRST)) u_pick (
    .vec    (nxt),
    .idx    (pick_idx),
    .found  (pick_found),
    .single (pick_single)
  );

  always_comb begin
    nb.idx  = IDX_MAX_W'(pick_idx);
    nb.last = !pick_found || pick_single;
    nb.none = !pick_found;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      pending <= '0;
      beat    <= '0;
    end else if (take) begin
      state   <= SCAN;
      pending <= nxt;
      beat    <= nb;
    end else if (fire) begin
      if (beat.last) begin
        state   <= IDLE;
        pending <= '0;
        beat    <= '0;
      end else begin
        pending <= nxt;
        beat    <= nb;
      end
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == SCAN);
  assign busy      = (state == SCAN);
  assign out_idx   = beat.idx[W-1:0];
  assign out_last  = beat.last;
  assign out_none  = beat.none;

  if (W < IDX_MAX_W) begin : g_pad
    logic unused_hi;
    assign unused_hi = ^beat.idx[IDX_MAX_W-1:W];
  end

`ifdef PRIORITY_SCAN_COUNT_EN
  logic [W:0] pop;

  always_comb begin
    pop = '0;
    for (int i = 0; i < N; i++) pop = pop + (W+1)'(in_vec[i]);
  end

  // A zero vector still owes its single none beat
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_count     <= '0;
      out_remaining <= '0;
    end else if (take) begin
      out_count     <= pop;
      out_remaining <= (pop == '0) ? (W+1)'(1) : pop;
    end else if (fire) begin
      out_remaining <= out_remaining - (W+1)'(1);
    end
  end
`endif

endmodule

// File: tb/tb_priority_scan_encoder.sv
// Directed bench: MSB-first N=8, LSB-first N=8 and MSB-first N=16 instances
// sharing handshake and reset stimulus.
module tb_priority_scan_encoder;

  logic        clk = 1'b0;
  logic        rst_n, in_valid, out_ready;
  logic [7:0]  vec8;
  logic [15:0] vec16;

  logic       a_in_ready, a_out_valid, a_out_last, a_out_none, a_busy;
  logic [2:0] a_out_idx;
  logic       b_in_ready, b_out_valid, b_out_last, b_out_none, b_busy;
  logic [2:0] b_out_idx;
  logic       c_in_ready, c_out_valid, c_out_last, c_out_none, c_busy;
  logic [3:0] c_out_idx;
`ifdef PRIORITY_SCAN_COUNT_EN
  logic [3:0] a_cnt, a_rem, b_cnt, b_rem;
  logic [4:0] c_cnt, c_rem;
`endif

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  priority_scan_encoder #(.N(8), .LSB_FIRST(0)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(a_in_ready),
    .in_vec(vec8), .out_valid(a_out_valid), .out_ready(out_ready),
    .out_idx(a_out_idx), .out_last(a_out_last), .out_none(a_out_none),
`ifdef PRIORITY_SCAN_COUNT_EN
    .out_count(a_cnt), .out_remaining(a_rem),
`endif
    .busy(a_busy)
  );

  priority_scan_encoder #(.N(8), .LSB_FIRST(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(b_in_ready),
    .in_vec(vec8), .out_valid(b_out_valid), .out_ready(out_ready),
    .out_idx(b_out_idx), .out_last(b_out_last), .out_none(b_out_none),
`ifdef PRIORITY_SCAN_COUNT_EN
    .out_count(b_cnt), .out_remaining(b_rem),
`endif
    .busy(b_busy)
  );

  priority_scan_encoder #(.N(16), .LSB_FIRST(0)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(c_in_ready),
    .in_vec(vec16), .out_valid(c_out_valid), .out_ready(out_ready),
    .out_idx(c_out_idx), .out_last(c_out_last), .out_none(c_out_none),
`ifdef PRIORITY_SCAN_COUNT_EN
    .out_count(c_cnt), .out_remaining(c_rem),
`endif
    .busy(c_busy)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int e_a, e_b, beats, cyc;
    logic [3:0] pat;
    int exp_idx[4];

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; vec8 = '0; vec16 = '0;
    tick();
    chk("rst_valid", a_out_valid, 0);
    chk("rst_busy",  a_busy, 0);
    chk("rst_idx",   a_out_idx, 0);
    chk("rst_last",  a_out_last, 0);
    chk("rst_none",  a_out_none, 0);
`ifdef PRIORITY_SCAN_COUNT_EN
    chk("rst_count", a_cnt, 0);
    chk("rst_rem",   a_rem, 0);
`endif
    tick();
    rst_n = 1'b1;
    tick();
    chk("rdy_a", a_in_ready, 1);
    chk("rdy_b", b_in_ready, 1);
    chk("rdy_c", c_in_ready, 1);

    // 1010_0100 with out_ready held high; u_c sees a zero vector
    vec8 = 8'b1010_0100; vec16 = 16'h0000; in_valid = 1'b1; out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("a0_valid", a_out_valid, 1);
    chk("a0_rdy",   a_in_ready, 0);
    chk("a0_busy",  a_busy, 1);
    chk("a0_idx",   a_out_idx, 7);
    chk("a0_last",  a_out_last, 0);
    chk("b0_idx",   b_out_idx, 2);
    chk("b0_last",  b_out_last, 0);
    chk("c_none",   c_out_none, 1);
    chk("c_nidx",   c_out_idx, 0);
    chk("c_nlast",  c_out_last, 1);
    chk("c_nvalid", c_out_valid, 1);
    tick();
    chk("a1_idx",  a_out_idx, 5);
    chk("a1_last", a_out_last, 0);
    chk("b1_idx",  b_out_idx, 5);
    chk("b1_last", b_out_last, 0);
    chk("c_idle_valid", c_out_valid, 0);
    chk("c_idle_rdy",   c_in_ready, 1);
    tick();
    chk("a2_idx",  a_out_idx, 2);
    chk("a2_last", a_out_last, 1);
    chk("a2_none", a_out_none, 0);
    chk("b2_idx",  b_out_idx, 7);
    chk("b2_last", b_out_last, 1);
    tick();
    chk("a_end_valid", a_out_valid, 0);
    chk("a_end_rdy",   a_in_ready, 1);
    chk("a_end_busy",  a_busy, 0);
    chk("b_end_valid", b_out_valid, 0);

    // zero vector on the 8-bit instances
    vec8 = 8'h00; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("z_valid", a_out_valid, 1);
    chk("z_none",  a_out_none, 1);
    chk("z_idx",   a_out_idx, 0);
    chk("z_last",  a_out_last, 1);
`ifdef PRIORITY_SCAN_COUNT_EN
    chk("z_count", a_cnt, 0);
    chk("z_rem",   a_rem, 1);
`endif
    tick();
    chk("z_end_valid", a_out_valid, 0);
    chk("z_end_rdy",   a_in_ready, 1);

    // all-ones with stalls: ready pattern 1,0,0,1 repeating
    vec8 = 8'hFF; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    pat = 4'b1001;
    e_a = 7; e_b = 0; beats = 0; cyc = 0;
    while (a_out_valid && cyc < 40) begin
      chk("ff_a_idx",  a_out_idx, e_a);
      chk("ff_a_last", a_out_last, (e_a == 0));
      chk("ff_b_idx",  b_out_idx, e_b);
      chk("ff_b_last", b_out_last, (e_b == 7));
      out_ready = pat[cyc % 4];
      tick();
      if (out_ready) begin
        beats++; e_a--; e_b++;
      end
      cyc++;
    end
    chk("ff_beats",   beats, 8);
    chk("ff_a_valid", a_out_valid, 0);
    chk("ff_b_valid", b_out_valid, 0);

    out_ready = 1'b1;
    repeat (3) tick();

`ifdef PRIORITY_SCAN_COUNT_EN
    vec8 = 8'b0110_1001; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    exp_idx = '{6, 5, 3, 0};
    for (int j = 0; j < 4; j++) begin
      chk("cnt_idx",   a_out_idx, exp_idx[j]);
      chk("cnt_count", a_cnt, 4);
      chk("cnt_rem",   a_rem, 4 - j);
      tick();
    end
    chk("cnt_end_valid", a_out_valid, 0);
    repeat (2) tick();
`else
    exp_idx = '{0, 0, 0, 0};
`endif

    // reset in the middle of a 16-bit scan
    vec16 = 16'h8001; in_valid = 1'b1; out_ready = 1'b0;
    tick();
    in_valid = 1'b0;
    chk("r_idx15",  c_out_idx, 15);
    chk("r_last",   c_out_last, 0);
    chk("r_valid",  c_out_valid, 1);
    out_ready = 1'b1;
    tick();
    rst_n = 1'b0;
    #1;
    chk("r_drop_valid", c_out_valid, 0);
    chk("r_drop_busy",  c_busy, 0);
    chk("r_drop_idx",   c_out_idx, 0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("r_rdy",   c_in_ready, 1);
    chk("r_quiet", c_out_valid, 0);
    tick();
    chk("r_quiet2", c_out_valid, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/priority_scan_encoder.md
Name: priority_scan_encoder

Overview:
- Parametrised, sequential successor to the team's combinational 8:3 priority encoder.
- Accepts an N-bit multi-hot vector over a valid/ready handshake.
- Emits the encoded index of every set bit, one per output beat, in priority order.
- Sits between interrupt/request aggregators and downstream index consumers (DMA channel select, IRQ dispatch).

Parameters:
- N, 8: input vector width; N >= 2.
- W, $clog2(N): index width; derived, not overridden.
- LSB_FIRST, 0: 0 = highest set bit served first (legacy order); 1 = lowest set bit first.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  N  multi-hot request vector
- out_valid  output  1  out_idx is valid
- out_ready  input  1  consumer accepts the current beat
- out_idx  output  W  encoded index of the current set bit
- out_last  output  1  current beat is the final one for this vector
- out_none  output  1  current beat reports an all-zero vector
- busy  output  1  a vector is held (state != IDLE)

Behaviour:
- Reset, asynchronous, on rst_n low:
  - state = IDLE; pending = 0
  - out_valid, out_idx, out_last, out_none, busy = 0
  - in_ready = 1 once rst_n is high
- States are IDLE and SCAN.
- IDLE:
  - in_ready = 1, out_valid = 0.
  - An in_valid && in_ready handshake at edge T captures in_vec into pending and moves to SCAN.
  - The first beat is presented registered at T+1; input-to-output latency is 1 cycle.
- SCAN:
  - in_ready = 0; in_vec is ignored.
  - out_idx is the priority bit of pending (MSB or LSB per LSB_FIRST).
  - out_last = 1 when pending has exactly one set bit.
- Beat transfer on out_valid && out_ready:
  - The served bit is cleared from pending.
  - The next index is registered for the following cycle, giving sustained throughput of 1 beat/cycle.
  - On the beat with out_last = 1, return to IDLE.
- Backpressure: while out_valid && !out_ready, out_idx, out_last, out_none and pending hold stable.
- Zero vector: accepted normally. It produces exactly one beat with out_none = 1, out_idx = 0, out_last = 1, then returns to IDLE. This replaces the legacy silent 0 output.
- Gap between vectors: in_ready rises the cycle after the last beat transfers, so there is one bubble cycle between vectors. There is no combinational path from out_ready to in_ready.
- All-ones vector: N beats, indices N-1..0 (or 0..N-1 when LSB_FIRST = 1).
- Reset mid-SCAN: the pending vector is discarded and no further beats are issued.
- Outputs are driven from registers only; in_ready is decoded from state.

Optional Feature:
- Macro: PRIORITY_SCAN_COUNT_EN.
- With the macro defined:
  - Adds output out_count [W:0]: popcount of the captured vector, registered at capture and held through SCAN.
  - Adds output out_remaining [W:0]: beats left including the current one; decrements on each beat transfer.
  - Both reset to 0. For a zero vector, out_count = 0 and out_remaining = 1 on the none beat.
- Without the macro: neither port exists and no popcount logic is built.

Decomposition:
- Package priority_scan_pkg holds:
  - state enum (IDLE, SCAN)
  - typedef for the beat struct {idx, last, none}
  - localparam helper for W
- One sub-module: priority_pick, combinational.
  - Parameters N, LSB_FIRST.
  - Input vec[N-1:0]; outputs idx[W-1:0], found, single (exactly one bit set).
  - The top instantiates it on the masked next-pending value.

Test Plan:
- N=8, LSB_FIRST=0, in_vec=8'b1010_0100, out_ready held 1 -> beats idx 7, 5, 2 on consecutive cycles starting T+1; out_last only on idx 2; in_ready returns 1 on the following cycle.
- Same vector with LSB_FIRST=1 -> idx 2, 5, 7; out_last on 7.
- in_vec=8'h00 -> single beat: out_none=1, out_idx=0, out_last=1; back to IDLE.
- in_vec=8'hFF with out_ready toggling 1,0,0,1,... -> exactly 8 beats 7..0; idx/last held stable during stalls; no beat lost or duplicated.
- N=16, in_vec=16'h8001, rst_n pulsed low after the first beat (idx 15) -> out_valid drops immediately, idx 0 never issued, in_ready=1 after reset release.
- PRIORITY_SCAN_COUNT_EN defined, in_vec=8'b0110_1001 -> out_count=4 throughout; out_remaining 4, 3, 2, 1 across beats idx 6, 5, 3, 0.
